// File: rtl/pat_seq.sv
// Program sequencer for the pat pattern processor: program counter plus a
// hardware call/return stack, with stall, stack-bounds protection and sticky errors.
module pat_seq #(
  parameter int unsigned I_ADR_WIDTH  = 10,
  parameter int unsigned OFS_WIDTH    = 8,
  parameter int unsigned STACK_DEPTH  = 8,
  parameter int unsigned SP_WIDTH     = 4,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   op_bf,
  input  logic                   op_bb,
  input  logic                   op_call,
  input  logic                   op_ret,
  input  logic                   cond_met,
  input  logic [OFS_WIDTH-1:0]   offset,
  input  logic                   err_clr,
  output logic [I_ADR_WIDTH-1:0] pc,
  output logic [SP_WIDTH-1:0]    depth,
  output logic                   stack_full,
  output logic                   stack_empty,
  output logic [I_ADR_WIDTH-1:0] ret_addr,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [I_ADR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [I_ADR_WIDTH-1:0] pc_nxt;
  logic [I_ADR_WIDTH-1:0] pc_inc;
  logic [I_ADR_WIDTH-1:0] ofs_ext;
  logic [SP_WIDTH-1:0]    depth_nxt;
  logic                   overflow_nxt;
  logic                   underflow_nxt;
  logic                   push;
  logic [IDX_W-1:0]       push_idx;
  logic [IDX_W-1:0]       top_idx;

  assign pc_inc   = pc + I_ADR_WIDTH'(1);
  assign ofs_ext  = I_ADR_WIDTH'(offset);
  assign push_idx = IDX_W'(depth);
  assign top_idx  = IDX_W'(depth - SP_WIDTH'(1));

  // Status views derived from registered state only
  always_comb begin
    stack_empty = (depth == '0);
    stack_full  = (depth == SP_WIDTH'(STACK_DEPTH));
    ret_addr    = stack_empty ? '0 : stack_mem[top_idx];
  end

  // Next-state: ret > call > bf > bb, each qualified by cond_met; stall freezes everything
  always_comb begin
    pc_nxt        = pc;
    depth_nxt     = depth;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    push          = 1'b0;
    if (!stall) begin
      pc_nxt = pc_inc;
      if (err_clr) begin
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
      end
      if (cond_met) begin
        if (op_ret) begin
          if (stack_empty) begin
            underflow_nxt = 1'b1;
          end else begin
            pc_nxt    = stack_mem[top_idx];
            depth_nxt = depth - SP_WIDTH'(1);
          end
        end else if (op_call) begin
          if (stack_full) begin
            overflow_nxt = 1'b1;
          end else begin
            push      = 1'b1;
            depth_nxt = depth + SP_WIDTH'(1);
            pc_nxt    = pc + ofs_ext;
          end
        end else if (op_bf) begin
          pc_nxt = pc + ofs_ext;
        end else if (op_bb) begin
          pc_nxt = pc - ofs_ext;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= I_ADR_WIDTH'(RESET_VECTOR);
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      depth     <= depth_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  // Stack storage is never cleared; depth alone defines validity
  always_ff @(posedge clk) begin
    if (push && reset) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule
